// File: rtl/packet_out_ctrl_if.sv
// packet_out_ctrl_if
// Bundles the signals of one output-port packet controller: the head-of-packet
// requests and flits from the input buffers, the one-hot grant/pop returned to
// them, the crossbar select, and the registered valid/ready downstream stage.
//
// Modports:
//   slave  - the controller itself (consumes req/data/last/rdy, drives the rest)
//   master - the surrounding switch logic or a testbench (the opposite view)
//
// Signals:
//   req_i        [PORT_N]         input k has a flit at its head for this output
//   data_i       [PORT_N*FLIT_W]  flit payloads, input k at [k*FLIT_W +: FLIT_W]
//   last_i       [PORT_N]         head flit of input k is a packet tail
//   gnt_o        [PORT_N]         one-hot pop to the winning input
//   mux_in_sel_o [$clog2(PORT_N)] locked input index (crossbar select)
//   busy_o                        a packet is in progress
//   vld_o / data_o / last_o       registered output flit
//   rdy_i                         downstream accepts when vld_o && rdy_i
interface packet_out_ctrl_if #(
  parameter int PORT_N = 5,
  parameter int FLIT_W = 8
);
  localparam int SEL_W = $clog2(PORT_N);

  logic [PORT_N-1:0]        req_i;
  logic [PORT_N*FLIT_W-1:0] data_i;
  logic [PORT_N-1:0]        last_i;
  logic [PORT_N-1:0]        gnt_o;
  logic [SEL_W-1:0]         mux_in_sel_o;
  logic                     busy_o;
  logic                     vld_o;
  logic [FLIT_W-1:0]        data_o;
  logic                     last_o;
  logic                     rdy_i;

  modport slave (
    input  req_i, data_i, last_i, rdy_i,
    output gnt_o, mux_in_sel_o, busy_o, vld_o, data_o, last_o
  );

  modport master (
    output req_i, data_i, last_i, rdy_i,
    input  gnt_o, mux_in_sel_o, busy_o, vld_o, data_o, last_o
  );
endinterface

// File: rtl/packet_out_ctrl.sv
// packet_out_ctrl
// Per-output-port packet controller of the mesh XY switch. Arbitrates between
// the head-of-packet requests of PORT_N input buffers, locks onto the winner for
// the whole wormhole packet (through its tail flit), pops flits from it with a
// one-hot grant, drives the crossbar select and feeds a registered valid/ready
// output stage.
//
// Ports:
//   clk_i   - clock, all state on the rising edge
//   rst_ni  - asynchronous active-low reset
//   bus     - packet_out_ctrl_if.slave (req/data/last in, gnt/sel/busy out,
//             vld/data/last out with rdy in)
//
// Build option:
//   PACKET_OUT_CTRL_RR_EN - when defined, arbitration is round-robin using a
//   registered pointer; otherwise the highest requesting index always wins.
module packet_out_ctrl #(
  parameter int PORT_N = 5,
  parameter int FLIT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  packet_out_ctrl_if.slave     bus
);
  localparam int SEL_W = $clog2(PORT_N);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [SEL_W-1:0]    winner;

  logic                vld_reg;
  logic [FLIT_W-1:0]   data_reg;
  logic                last_reg;

  logic [PORT_N-1:0]   gnt;
  logic                can_load;
  logic                load;
  logic [FLIT_W-1:0]   data_sel;
  logic                last_sel;

  // Payload and tail flag of the locked input, selected with constant indices.
  always_comb begin
    data_sel = '0;
    last_sel = 1'b0;
    for (int gi = 0; gi < PORT_N; gi++) begin
      if (sel_reg == SEL_W'(gi)) begin
        data_sel = bus.data_i[gi*FLIT_W +: FLIT_W];
        last_sel = bus.last_i[gi];
      end
    end
  end

`ifdef PACKET_OUT_CTRL_RR_EN
  logic [SEL_W-1:0] ptr_reg, ptr_next;

  // Search descends from ptr with wrap-around. Offsets are visited from the
  // farthest to the nearest so that the nearest asserted request overwrites
  // every other candidate and wins.
  always_comb begin
    winner = ptr_reg;
    for (int off = PORT_N - 1; off >= 0; off--) begin
      for (int gi = 0; gi < PORT_N; gi++) begin
        if (bus.req_i[gi] && (((int'(ptr_reg) - off + PORT_N) % PORT_N) == gi)) begin
          winner = SEL_W'(gi);
        end
      end
    end
  end

  // After a tail from input k the search restarts just below k.
  always_comb begin
    ptr_next = ptr_reg;
    if (load && last_sel) begin
      ptr_next = (sel_reg == '0) ? SEL_W'(PORT_N - 1) : sel_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg <= SEL_W'(PORT_N - 1);
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  // Fixed priority: ascending scan, so the highest asserted index wins.
  always_comb begin
    winner = '0;
    for (int gi = 0; gi < PORT_N; gi++) begin
      if (bus.req_i[gi]) begin
        winner = SEL_W'(gi);
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
    end
  end

  // Next-state logic. The lock is released only when the tail is actually
  // popped; a starved locked input simply holds the lock.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.req_i) begin
          state_next = LOCKED;
          sel_next   = winner;
        end
      end
      LOCKED: begin
        if (load && last_sel) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic. The grant depends only on state, sel, req, vld and rdy, so
  // backpressure removes it in the same cycle without touching the payload path.
  always_comb begin
    can_load = !vld_reg || bus.rdy_i;
    for (int gi = 0; gi < PORT_N; gi++) begin
      gnt[gi] = (state_reg == LOCKED) && (sel_reg == SEL_W'(gi)) &&
                bus.req_i[gi] && can_load;
    end
  end

  assign load = |gnt;

  // Registered output stage: load on a grant, drop valid once accepted, hold
  // everything while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_reg  <= 1'b0;
      data_reg <= '0;
      last_reg <= 1'b0;
    end else if (load) begin
      vld_reg  <= 1'b1;
      data_reg <= data_sel;
      last_reg <= last_sel;
    end else if (bus.rdy_i) begin
      vld_reg  <= 1'b0;
    end
  end

  assign bus.gnt_o        = gnt;
  assign bus.mux_in_sel_o = sel_reg;
  assign bus.busy_o       = (state_reg == LOCKED);
  assign bus.vld_o        = vld_reg;
  assign bus.data_o       = data_reg;
  assign bus.last_o       = last_reg;
endmodule

// File: tb/tb_packet_out_ctrl.sv
`timescale 1ns/1ps
module tb_packet_out_ctrl;
  localparam int PORT_N = 5;
  localparam int FLIT_W = 8;
  localparam int SEL_W  = $clog2(PORT_N);

  typedef logic [FLIT_W:0] flit_t;   // {last, payload}

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  packet_out_ctrl_if #(.PORT_N(PORT_N), .FLIT_W(FLIT_W)) bus ();

  packet_out_ctrl #(.PORT_N(PORT_N), .FLIT_W(FLIT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream input buffers, expected output stream, observed output stream.
  flit_t             src_q [PORT_N][$];
  flit_t             exp_q [$];
  logic [FLIT_W-1:0] seen_q [$];
  int                seen_cyc [$];
  int                accepted = 0;

  int  checks = 0;
  int  errors = 0;
  bit  gap_en = 1'b0;
  bit  rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference arbitration: which input should win a given request vector.
`ifdef PACKET_OUT_CTRL_RR_EN
  function automatic int pick(input logic [PORT_N-1:0] r, input int ptr);
    for (int j = 0; j < PORT_N; j++) begin
      int c;
      c = (ptr - j + PORT_N) % PORT_N;
      if (r[c]) return c;
    end
    return 0;
  endfunction
`else
  function automatic int pick(input logic [PORT_N-1:0] r);
    for (int k = PORT_N - 1; k >= 0; k--) begin
      if (r[k]) return k;
    end
    return 0;
  endfunction
`endif

  // Upstream driver: present each buffer head, optional random starvation and
  // random downstream backpressure.
  initial begin : driver
    logic [PORT_N-1:0]        r;
    logic [PORT_N-1:0]        l;
    logic [PORT_N*FLIT_W-1:0] d;
    bus.req_i  = '0;
    bus.data_i = '0;
    bus.last_i = '0;
    bus.rdy_i  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      r = '0;
      l = '0;
      d = '0;
      for (int k = 0; k < PORT_N; k++) begin
        d[k*FLIT_W +: FLIT_W] = FLIT_W'($urandom);
        l[k] = 1'($urandom);
        if (src_q[k].size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
          r[k] = 1'b1;
          d[k*FLIT_W +: FLIT_W] = src_q[k][0][FLIT_W-1:0];
          l[k] = src_q[k][0][FLIT_W];
        end
      end
      bus.req_i  = r;
      bus.data_i = d;
      bus.last_i = l;
      bus.rdy_i  = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Packet-level reference model: decides the owner of the output, checks the
  // grant/select/busy rules, consumes popped flits and pushes whole packets
  // into the scoreboard at arbitration time.
  initial begin : model
    bit                m_locked;
    int                m_owner;
    int                m_ptr;
    logic [PORT_N-1:0] r;
    logic [PORT_N-1:0] g;
    logic [PORT_N-1:0] eg;
    flit_t             f;
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = PORT_N - 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_locked = 1'b0;
        m_ptr    = PORT_N - 1;
        exp_q.delete();
        continue;
      end
      r = bus.req_i;
      g = bus.gnt_o;
      if (m_locked) begin
        eg = '0;
        if (r[m_owner] && (!bus.vld_o || bus.rdy_i)) eg[m_owner] = 1'b1;
        chk("gnt_locked", 32'(g), 32'(eg));
        chk("mux_sel", 32'(bus.mux_in_sel_o), 32'(m_owner));
        chk("busy_locked", 32'(bus.busy_o), 32'd1);
        if (g[m_owner] && src_q[m_owner].size() != 0) begin
          f = src_q[m_owner].pop_front();
          if (f[FLIT_W]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner == 0) ? PORT_N - 1 : m_owner - 1;
          end
        end
      end else begin
        chk("gnt_idle", 32'(g), 32'd0);
        chk("busy_idle", 32'(bus.busy_o), 32'd0);
        if (|r) begin
`ifdef PACKET_OUT_CTRL_RR_EN
          m_owner = pick(r, m_ptr);
`else
          m_owner = pick(r);
`endif
          m_locked = 1'b1;
          for (int i = 0; i < src_q[m_owner].size(); i++) begin
            exp_q.push_back(src_q[m_owner][i]);
            if (src_q[m_owner][i][FLIT_W]) break;
          end
        end
      end
    end
  end

  // Output monitor: compares each accepted flit against the scoreboard and
  // checks that a stalled flit is held unchanged.
  initial begin : monitor
    bit                prev_stall;
    logic [FLIT_W-1:0] prev_data;
    logic              prev_last;
    flit_t             e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("stall_vld", 32'(bus.vld_o), 32'd1);
        chk("stall_data", 32'(bus.data_o), 32'(prev_data));
        chk("stall_last", 32'(bus.last_o), 32'(prev_last));
      end
      if (bus.vld_o && bus.rdy_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", 32'(bus.data_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.data_o), 32'(e[FLIT_W-1:0]));
          chk("out_last", 32'(bus.last_o), 32'(e[FLIT_W]));
        end
        seen_q.push_back(bus.data_o);
        seen_cyc.push_back(cyc);
        accepted++;
      end
      prev_stall = bus.vld_o && !bus.rdy_i;
      prev_data  = bus.data_o;
      prev_last  = bus.last_o;
    end
  end

  task automatic wait_accepted(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (accepted < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(accepted >= target), 32'd1);
  endtask

  // Single packet from input k, n flits base, base+1, ...; checks the exact
  // cycle-by-cycle timing relative to the request cycle 0.
  task automatic single_pkt(input int k, input int n, input logic [FLIT_W-1:0] base);
    flit_t             f;
    logic [PORT_N-1:0] eg;
    for (int j = 0; j < n; j++) begin
      f = {(j == n - 1), base + FLIT_W'(j)};
      src_q[k].push_back(f);
    end
    for (int i = 0; i <= n + 1; i++) begin
      @(negedge clk);
      eg = '0;
      if (i >= 1 && i <= n) eg[k] = 1'b1;
      chk("sp_gnt", 32'(bus.gnt_o), 32'(eg));
      chk("sp_busy", 32'(bus.busy_o), 32'(i >= 1 && i <= n));
      chk("sp_vld", 32'(bus.vld_o), 32'(i >= 2));
      if (i >= 1) chk("sp_sel", 32'(bus.mux_in_sel_o), 32'(k));
      if (i >= 2) begin
        chk("sp_data", 32'(bus.data_o), 32'(base + FLIT_W'(i - 2)));
        chk("sp_last", 32'(bus.last_o), 32'(i == n + 1));
      end
    end
  endtask

  initial begin : main
    int base;
    int total;
    int len;
    flit_t f;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(bus.vld_o), 32'd0);
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_sel", 32'(bus.mux_in_sel_o), 32'd0);
    chk("rst_data", 32'(bus.data_o), 32'd0);
    chk("rst_last", 32'(bus.last_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef PACKET_OUT_CTRL_RR_EN
    // All inputs with back-to-back single-flit packets: 4,3,2,1,0,4,...
    base = accepted;
    for (int k = 0; k < PORT_N; k++) begin
      for (int p = 0; p < 2; p++) begin
        f = {1'b1, FLIT_W'(k * 16 + p)};
        src_q[k].push_back(f);
      end
    end
    wait_accepted(base + 2 * PORT_N, 200, "rr_done");
    for (int i = 0; i < 2 * PORT_N; i++) begin
      if (seen_q.size() > base + i) begin
        chk("rr_order", 32'(seen_q[base + i][7:4]), 32'(PORT_N - 1 - (i % PORT_N)));
      end
    end
`else
    // Contention 4,1,0 held: whole packets in priority order, one bubble.
    begin
      int ord [3];
      ord = '{4, 1, 0};
      base = accepted;
      for (int q = 0; q < 3; q++) begin
        f = {1'b0, FLIT_W'(ord[q] * 16)};
        src_q[ord[q]].push_back(f);
        f = {1'b1, FLIT_W'(ord[q] * 16 + 1)};
        src_q[ord[q]].push_back(f);
      end
      wait_accepted(base + 6, 200, "cont_done");
      for (int i = 0; i < 6; i++) begin
        if (seen_q.size() > base + i) begin
          chk("cont_order", 32'(seen_q[base + i][7:4]), 32'(ord[i / 2]));
          if (i > 0) chk("cont_gap", 32'(seen_cyc[base + i] - seen_cyc[base + i - 1]),
                         32'((i % 2 == 0) ? 2 : 1));
        end
      end
    end
`endif
    repeat (3) @(negedge clk);

    // Single 3-flit packet on input 2.
    single_pkt(2, 3, 8'hA1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a 4-flit packet from input 1.
    base = accepted;
    for (int j = 0; j < 4; j++) begin
      f = {(j == 3), FLIT_W'(8'hB0 + j)};
      src_q[1].push_back(f);
    end
    wait_accepted(base + 2, 50, "midrst_progress");
    chk("midrst_busy_before", 32'(bus.busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < PORT_N; k++) src_q[k].delete();
    #1;
    chk("midrst_vld", 32'(bus.vld_o), 32'd0);
    chk("midrst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    single_pkt(3, 2, 8'hC0);
    repeat (2) @(negedge clk);

    // Randomised traffic with starvation gaps and backpressure.
    gap_en   = 1'b1;
    rdy_rand = 1'b1;
    base  = accepted;
    total = 0;
    for (int k = 0; k < PORT_N; k++) begin
      for (int p = 0; p < 5; p++) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          f = {(j == len - 1), FLIT_W'($urandom)};
          src_q[k].push_back(f);
          total++;
        end
      end
    end
    wait_accepted(base + total, 5000, "rand_done");
    repeat (4) @(negedge clk);
    chk("exp_empty", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < PORT_N; k++) chk("src_empty", 32'(src_q[k].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
